// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder-subtractor.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // The saturation limits are computed at this width and then cast down.
  localparam int unsigned SAT_MAX_W = 64;
  localparam logic [SAT_MAX_W-1:0] SAT_ONE = {{(SAT_MAX_W-1){1'b0}}, 1'b1};

  // Signed limit for a given width: most negative when neg=1, else most positive.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned width, input logic neg);
    logic [SAT_MAX_W-1:0] msb;
    msb = SAT_ONE << (width - 1);
    return neg ? msb : (msb - SAT_ONE);
  endfunction

  // Pipeline geometry check, evaluated at elaboration.
  function automatic bit geometry_ok(input int unsigned width, input int unsigned stages);
    return (width >= 2) && (stages != 0) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CW-bit full adder slice with carry out and signed-overflow at its MSB.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          msb_ovf
);

  logic [CW:0] sum;

  assign sum     = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign s       = sum[CW-1:0];
  assign cout    = sum[CW];
  assign msb_ovf = (a[CW-1] == b[CW-1]) && (sum[CW-1] != a[CW-1]);

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder-subtractor, one CW-bit chunk per stage, valid/ready on both sides.
// Optional build macro ADDSUB_PIPE_SAT_EN saturates s to the signed limit on overflow.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = WIDTH / STAGES;

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("addsub_pipe: WIDTH must be >= 2 and an exact multiple of STAGES");
  end

  logic adv;

  // Level k holds an operation before chunk k is resolved: operands, carry-in and lower sum chunks.
  logic [STAGES-1:0] v_r;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];

  logic [CW-1:0]     sum_c   [STAGES];
  logic              carry_c [STAGES];
  logic              ovf_c   [STAGES];

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r[0] <= 1'b0;
      c_r[0] <= 1'b0;
      a_r[0] <= '0;
      b_r[0] <= '0;
      s_r[0] <= '0;
    end else if (adv) begin
      v_r[0] <= in_valid;
      c_r[0] <= (sub == OP_SUB);
      a_r[0] <= a;
      b_r[0] <= (sub == OP_SUB) ? ~b : b;
      s_r[0] <= '0;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] s_merged;

    addsub_chunk #(.CW(CW)) u_chunk (
      .a       (a_r[k][k*CW +: CW]),
      .b       (b_r[k][k*CW +: CW]),
      .cin     (c_r[k]),
      .s       (sum_c[k]),
      .cout    (carry_c[k]),
      .msb_ovf (ovf_c[k])
    );

    always_comb begin
      s_merged              = s_r[k];
      s_merged[k*CW +: CW]  = sum_c[k];
    end

    if (k < STAGES - 1) begin : g_mid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_r[k+1] <= 1'b0;
          c_r[k+1] <= 1'b0;
          a_r[k+1] <= '0;
          b_r[k+1] <= '0;
          s_r[k+1] <= '0;
        end else if (adv) begin
          v_r[k+1] <= v_r[k];
          c_r[k+1] <= carry_c[k];
          a_r[k+1] <= a_r[k];
          b_r[k+1] <= b_r[k];
          s_r[k+1] <= s_merged;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] s_final;

`ifdef ADDSUB_PIPE_SAT_EN
      // Overflow direction follows A's sign: positive A can only overflow upward.
      assign s_final = ovf_c[k] ? WIDTH'(sat_limit(WIDTH, a_r[k][WIDTH-1])) : s_merged;
`else
      assign s_final = s_merged;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          s         <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (adv) begin
          out_valid <= v_r[k];
          s         <= s_final;
          cout      <= carry_c[k];
          ovf       <= ovf_c[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Randomized and directed bench for addsub_pipe, scoreboarded against an arithmetic reference model.
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned ST = 4;

  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [W-1:0] s;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] s;

  // Variants with other stage counts, always draining.
  logic         x_rdy = 1'b1;
  logic         x_in_ready [3];
  logic         x_valid    [3];
  logic         x_cout     [3];
  logic         x_ovf      [3];
  logic [W-1:0] x_s        [3];

  addsub_pipe #(.WIDTH(W), .STAGES(ST)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );
  addsub_pipe #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x_in_ready[0]), .a(a), .b(b), .sub(sub),
    .out_valid(x_valid[0]), .out_ready(x_rdy), .s(x_s[0]), .cout(x_cout[0]), .ovf(x_ovf[0])
  );
  addsub_pipe #(.WIDTH(W), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x_in_ready[1]), .a(a), .b(b), .sub(sub),
    .out_valid(x_valid[1]), .out_ready(x_rdy), .s(x_s[1]), .cout(x_cout[1]), .ovf(x_ovf[1])
  );
  addsub_pipe #(.WIDTH(W), .STAGES(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x_in_ready[2]), .a(a), .b(b), .sub(sub),
    .out_valid(x_valid[2]), .out_ready(x_rdy), .s(x_s[2]), .cout(x_cout[2]), .ovf(x_ovf[2])
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
    longint ux, uy, sx, sy, ur, sr;
    longint smax;
    res_t   r;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    smax = (longint'(1) << (W - 1)) - 1;
    if (op == OP_SUB) begin
      ur = ux - uy;
      sr = sx - sy;
      r.cout = (ux >= uy);
    end else begin
      ur = ux + uy;
      sr = sx + sy;
      r.cout = (ur >= (longint'(1) << W));
    end
    r.s   = ur[W-1:0];
    r.ovf = (sr > smax) || (sr < -smax - 1);
`ifdef ADDSUB_PIPE_SAT_EN
    if (r.ovf) r.s = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard: results in acceptance order, plus the advance count at which each should appear.
  res_t        exp_q [$];
  int unsigned due_q [$];
  int unsigned adv_cnt = 0;
  int unsigned out_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [W-1:0] prev_s;
  logic        prev_cout, prev_ovf;

  always @(negedge clk) begin
    res_t        e;
    int unsigned due;
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, out_ready || !out_valid);
      if (prev_stall) begin
        check("hold_s", s, prev_s);
        check("hold_cout", cout, prev_cout);
        check("hold_ovf", ovf, prev_ovf);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          e   = exp_q.pop_front();
          due = due_q.pop_front();
          check("sb_s", s, e.s);
          check("sb_cout", cout, e.cout);
          check("sb_ovf", ovf, e.ovf);
          check("sb_latency", adv_cnt, due);
        end
      end
      // Accepting edge is itself an advance; STAGES further advances later the result is visible.
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_op(a, b, sub));
        due_q.push_back(adv_cnt + 1 + ST);
      end
      if (in_ready) adv_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_s     = s;
      prev_cout  = cout;
      prev_ovf   = ovf;
    end
  end

  // One op into an empty pipeline; every DUT variant must return it after exactly its stage count.
  task automatic directed(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                          input logic dsub, input logic [W-1:0] es, input logic ec, input logic eo);
    int           lat [4];
    logic [W-1:0] rs  [4];
    logic         rc  [4];
    logic         ro  [4];
    int           exp_lat [4];
    exp_lat = '{ST, 1, 2, 16};
    for (int i = 0; i < 4; i++) begin
      lat[i] = -1; rs[i] = '0; rc[i] = 1'b0; ro[i] = 1'b0;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = da; b = db; sub = dsub;
    for (int t = 0; t < 24; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && lat[0] < 0) begin
        lat[0] = t; rs[0] = s; rc[0] = cout; ro[0] = ovf;
      end
      for (int i = 0; i < 3; i++) begin
        if (x_valid[i] && lat[i+1] < 0) begin
          lat[i+1] = t; rs[i+1] = x_s[i]; rc[i+1] = x_cout[i]; ro[i+1] = x_ovf[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_lat%0d", tag, exp_lat[i]), lat[i], exp_lat[i]);
      check($sformatf("%s_s%0d", tag, exp_lat[i]), rs[i], es);
      check($sformatf("%s_cout%0d", tag, exp_lat[i]), rc[i], ec);
      check($sformatf("%s_ovf%0d", tag, exp_lat[i]), ro[i], eo);
    end
  endtask

`ifdef ADDSUB_PIPE_SAT_EN
  localparam logic [W-1:0] POS_OVF_S = 16'h7FFF;
  localparam logic [W-1:0] NEG_OVF_S = 16'h8000;
`else
  localparam logic [W-1:0] POS_OVF_S = 16'h8000;
  localparam logic [W-1:0] NEG_OVF_S = 16'h7FFF;
`endif

  initial begin
    int unsigned sent;
    int unsigned base;

    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    directed("add",          16'h1234, 16'h0F0F, OP_ADD, 16'h2143, 1'b0, 1'b0);
    directed("sub_borrow",   16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_noborrow", 16'h0007, 16'h0005, OP_SUB, 16'h0002, 1'b1, 1'b0);
    directed("ovf_pos",      16'h7FFF, 16'h0001, OP_ADD, POS_OVF_S, 1'b0, 1'b1);
    directed("ovf_neg",      16'h8000, 16'h0001, OP_SUB, NEG_OVF_S, 1'b1, 1'b1);
    directed("carry_chunk",  16'h00FF, 16'h0001, OP_ADD, 16'h0100, 1'b0, 1'b0);
    directed("carry_all",    16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b0);

    // Eight back-to-back ops with a three-cycle consumer stall mid-stream.
    sent = 0;
    base = out_cnt;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 6 && c < 9);
      in_valid  = (sent < 8);
      a   = W'(16'h1111 * (sent + 1));
      b   = W'(16'h0F0F + sent);
      sub = sent[0];
      @(negedge clk);
      if (c >= 6 && c < 9) check("stall_in_ready", in_ready, 1'b0);
      if (in_valid && in_ready) sent++;
    end
    check("stream_sent", sent, 8);
    check("stream_emitted", out_cnt - base, 8);

    // Random traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = rand_opnd();
      b   = rand_opnd();
      sub = $urandom_range(0, 1) == 1;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("drained", exp_q.size(), 0);

    // Fill the pipe against a stalled consumer, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h1111; b = 16'h2222; sub = OP_ADD;
    repeat (10) @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_s", s, 16'h3333);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_s", s, 16'h0000);
    check("mid_rst_cout", cout, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    base = out_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_out", out_cnt - base, 0);
    directed("post_rst", 16'h4321, 16'h1234, OP_SUB, 16'h30ED, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
